// File: rtl/alu_pkg.sv
// alu_pkg: ALU mode codes and issue-stage FSM state encoding shared by the ALU and its issue stage.
package alu_pkg;
  localparam logic [3:0] MODE_SHL = 4'd0;
  localparam logic [3:0] MODE_ADD = 4'd4;
  localparam logic [3:0] MODE_SUB = 4'd5;
  localparam logic [3:0] MODE_FFS = 4'd15;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/retire stage in front of the combinational ALU; one op per two cycles.
// Ports: req_* valid/ready request channel (req_chain reuses the last result as A and the last carry as Cin),
//   alu_* registered ALU inputs and ALU results, rsp_* valid/ready registered response,
//   sticky_ovf accumulates retired overflows (clr_sticky wins), op_count counts retired responses.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W      = 16,
  parameter int MODE_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W-1:0]      req_a,
  input  logic [W-1:0]      req_b,
  input  logic              req_cin,
  input  logic [MODE_W-1:0] req_mode,
  input  logic              req_chain,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic              alu_cin,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [W-1:0]      alu_y,
  input  logic              alu_cout,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_y,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              sticky_ovf,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  op_count
);
  state_t state;
  logic [W-1:0] last_y;
  logic last_cout, retire, accept, arith;
  assign rsp_valid = state == RESP;
  assign retire = rsp_valid & rsp_ready;
  // A new request may enter in the same cycle the current result retires.
  assign req_ready = (state == IDLE) | retire;
  assign accept = req_valid & req_ready;
  // The ALU drives Cout/Overflow meaningfully only for add and subtract.
  assign arith = (alu_mode == MODE_W'(MODE_ADD)) | (alu_mode == MODE_W'(MODE_SUB));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
      alu_mode <= '0;
      rsp_y <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf <= 1'b0;
      last_y <= '0;
      last_cout <= 1'b0;
      sticky_ovf <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        alu_a <= req_chain ? last_y : req_a;
        alu_cin <= req_chain ? last_cout : req_cin;
        alu_b <= req_b;
        alu_mode <= req_mode;
      end
      if (state == EXEC) begin
        rsp_y <= alu_y;
        rsp_cout <= arith & alu_cout;
        rsp_ovf <= arith & alu_ovf;
        last_y <= alu_y;
        last_cout <= arith & alu_cout;
      end
      if (retire) op_count <= op_count + CNT_W'(1);
      sticky_ovf <= !clr_sticky & (sticky_ovf | (retire & rsp_ovf));
      state <= accept ? EXEC : (state == EXEC) ? RESP : retire ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl driving a behavioural 16-bit ALU.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_cin, req_chain, alu_cin, alu_cout, alu_ovf;
  logic rsp_valid, rsp_ready, rsp_cout, rsp_ovf, sticky_ovf, clr_sticky;
  logic [15:0] req_a, req_b, alu_a, alu_b, alu_y, rsp_y, op_count;
  logic [3:0] req_mode, alu_mode;
  logic s_req_ready, s_alu_cin, s_rsp_valid, s_rsp_cout, s_rsp_ovf, s_sticky_ovf;
  logic [15:0] s_alu_a, s_alu_b, s_rsp_y;
  logic [3:0] s_alu_mode, s_op_count;
  int n_checks = 0;
  int n_fails = 0;
  int exp_cnt;
  always #5 clk = ~clk;
  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_mode(req_mode), .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
  );
  // Narrow-counter twin running in lockstep so the counter wrap is reached quickly.
  alu_issue_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_mode(req_mode), .req_chain(req_chain),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_cin(s_alu_cin), .alu_mode(s_alu_mode),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_y(s_rsp_y), .rsp_cout(s_rsp_cout),
    .rsp_ovf(s_rsp_ovf), .sticky_ovf(s_sticky_ovf), .clr_sticky(clr_sticky), .op_count(s_op_count)
  );
  // Behavioural ALU; Cout/Overflow are deliberately 1 outside add/sub to expose missing masking.
  always_comb begin
    alu_y = alu_a ^ alu_b;
    alu_cout = 1'b1;
    alu_ovf = 1'b1;
    if (alu_mode == 4'd4) begin
      {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      alu_ovf = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
    end else if (alu_mode == 4'd5) begin
      {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
      alu_ovf = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
    end else if (alu_mode == 4'd15) begin
      alu_y = 16'd0;
      for (int i = 15; i >= 0; i--) if (alu_a[i]) alu_y = 16'(i);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [3:0] mode, input logic chain);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_cin = cin;
    req_mode = mode;
    req_chain = chain;
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_cin = 1'b0;
    req_mode = '0;
    req_chain = 1'b0;
    rsp_ready = 1'b0;
    clr_sticky = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    rst_n = 1'b1;
    step();
    req(16'h7FFF, 16'h0001, 1'b0, 4'd4, 1'b0);
    step();
    req_valid = 1'b0;
    check("t1_alu_a", 32'(alu_a), 32'h7FFF);
    check("t1_alu_mode", 32'(alu_mode), 32'd4);
    check("t1_exec_req_ready", 32'(req_ready), 32'd0);
    check("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_y", 32'(rsp_y), 32'h8000);
    check("t1_rsp_cout", 32'(rsp_cout), 32'd0);
    check("t1_rsp_ovf", 32'(rsp_ovf), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t1_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_op_count", 32'(op_count), 32'd1);
    check("t1_sticky", 32'(sticky_ovf), 32'd1);
    req(16'hFFFF, 16'h0001, 1'b0, 4'd4, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("t2_rsp_y", 32'(rsp_y), 32'h0000);
    check("t2_rsp_cout", 32'(rsp_cout), 32'd1);
    req(16'h1234, 16'h0000, 1'b0, 4'd4, 1'b1);
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("t2_chain_alu_a", 32'(alu_a), 32'h0000);
    check("t2_chain_alu_cin", 32'(alu_cin), 32'd1);
    check("t2_op_count", 32'(op_count), 32'd2);
    step();
    check("t2_chain_rsp_y", 32'(rsp_y), 32'h0001);
    check("t2_chain_rsp_cout", 32'(rsp_cout), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t2_op_count_end", 32'(op_count), 32'd3);
    req(16'h7FFF, 16'h7FFF, 1'b0, 4'd4, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("t3_add_rsp_y", 32'(rsp_y), 32'hFFFE);
    check("t3_add_rsp_ovf", 32'(rsp_ovf), 32'd1);
    req(16'h0100, 16'h0000, 1'b0, 4'd15, 1'b0);
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("t3_op_count", 32'(op_count), 32'd4);
    step();
    check("t3_ffs_rsp_y", 32'(rsp_y), 32'h0008);
    check("t3_ffs_rsp_cout", 32'(rsp_cout), 32'd0);
    check("t3_ffs_rsp_ovf", 32'(rsp_ovf), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t3_sticky", 32'(sticky_ovf), 32'd1);
    req(16'h0005, 16'h0007, 1'b1, 4'd5, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("t4_sub_rsp_y", 32'(rsp_y), 32'hFFFE);
    check("t4_sub_rsp_cout", 32'(rsp_cout), 32'd0);
    req(16'h0001, 16'h0002, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_stall_rsp_y", 32'(rsp_y), 32'hFFFE);
      check("t4_stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t4_stall_req_ready", 32'(req_ready), 32'd0);
      check("t4_stall_op_count", 32'(op_count), 32'd5);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("t4_b2b_op_count", 32'(op_count), 32'd6);
    check("t4_b2b_alu_a", 32'(alu_a), 32'h0001);
    step();
    check("t4_b2b_rsp_y", 32'(rsp_y), 32'h0003);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t4_op_count_end", 32'(op_count), 32'd7);
    req(16'h0002, 16'h0003, 1'b0, 4'd4, 1'b0);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_alu_a", 32'(alu_a), 32'd0);
    check("t5_rst_alu_b", 32'(alu_b), 32'd0);
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_op_count", 32'(op_count), 32'd0);
    check("t5_rst_sticky", 32'(sticky_ovf), 32'd0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_no_op_count", 32'(op_count), 32'd0);
    end
    rsp_ready = 1'b0;
    req(16'h7FFF, 16'h0001, 1'b0, 4'd4, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("t6_rsp_ovf", 32'(rsp_ovf), 32'd1);
    rsp_ready = 1'b1;
    clr_sticky = 1'b1;
    step();
    rsp_ready = 1'b0;
    clr_sticky = 1'b0;
    check("t6_clr_wins_sticky", 32'(sticky_ovf), 32'd0);
    check("t6_op_count", 32'(op_count), 32'd1);
    exp_cnt = 1;
    for (int i = 0; i < 16; i++) begin
      req(16'(i), 16'(i), 1'b0, 4'd4, 1'b0);
      step();
      req_valid = 1'b0;
      step();
      check("t7_rsp_y", 32'(rsp_y), 32'(2 * i));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("t7_op_count", 32'(op_count), 32'(exp_cnt));
      check("t7_small_op_count", 32'(s_op_count), 32'(exp_cnt % 16));
    end
    check("t7_sticky", 32'(sticky_ovf), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
